// File: rtl/imm_ext_pkg.sv
// Shared types and the immediate decoder for the immediate-extension stage.
// Define IMM_EXT_ZICSR_EN to enable the CSR zimm format on src 6.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_B,
        IMM_S,
        IMM_J,
        IMM_U,
        IMM_SHAMT,
        IMM_ZIMM,
        IMM_RSVD
    } imm_src_t;

    // 32-bit raw immediate plus how it widens to XLEN
    typedef struct packed {
        logic [31:0] raw;
        logic        sx;
        logic        illegal;
    } imm_dec_t;

    function automatic imm_dec_t decode_imm(
        input logic [31:0] i,
        input imm_src_t    src,
        input logic        rv64
    );
        imm_dec_t d;
        d.raw     = '0;
        d.sx      = 1'b1;
        d.illegal = 1'b0;
        case (src)
            IMM_I: d.raw = {{20{i[31]}}, i[31:20]};
            IMM_B: d.raw = {{19{i[31]}}, i[31], i[7],
                            i[30:25], i[11:8], 1'b0};
            IMM_S: d.raw = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_J: d.raw = {{11{i[31]}}, i[31], i[19:12],
                            i[20], i[30:21], 1'b0};
            IMM_U: d.raw = {i[31:12], 12'b0};
            IMM_SHAMT: begin
                d.sx = 1'b0;
                if (rv64) begin
                    d.raw = {26'b0, i[25:20]};
                end else if (i[25]) begin
                    d.illegal = 1'b1;
                end else begin
                    d.raw = {27'b0, i[24:20]};
                end
            end
`ifdef IMM_EXT_ZICSR_EN
            IMM_ZIMM: begin
                d.sx  = 1'b0;
                d.raw = {27'b0, i[19:15]};
            end
`endif
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between decode, the immediate buffer and execute.
// master drives the producer/consumer controls, slave is the buffer.
interface imm_ext_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic             out_illegal;
    logic [CNT_W-1:0] out_count;

    modport master (
        output flush, in_valid, in_instr, in_imm_src, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_illegal,
        input  out_count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_imm_src, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_illegal,
        output out_count
    );

endinterface

// File: rtl/imm_ext_fifo.sv
// Synchronous in-order buffer with flush and occupancy count.
// Pointers wrap explicitly so any DEPTH >= 2 works.
module imm_ext_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (flush) begin
            // storage is left stale; only the bookkeeping is cleared
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Buffered immediate extension: decode imm + PC-relative target, queue them.
// Build with IMM_EXT_ZICSR_EN defined to accept CSR zimm on src 6.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    imm_ext_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    imm_dec_t         dec;
    logic [XLEN-1:0]  imm;
    entry_t           new_entry;
    entry_t           head;
    logic [ENTRY_W-1:0] head_bits;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             unused_opcode;

    // opcode bits never affect the immediate
    assign unused_opcode = ^bus.in_instr[6:0];

    always_comb begin
        dec = decode_imm(bus.in_instr, imm_src_t'(bus.in_imm_src),
                         XLEN == 64);
        imm = dec.sx ? XLEN'($signed(dec.raw)) : XLEN'(dec.raw);
        new_entry.imm     = imm;
        new_entry.target  = bus.in_pc + imm;
        new_entry.illegal = dec.illegal;
    end

    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready;

    imm_ext_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.flush),
        .push   (push),
        .wr_data(new_entry),
        .pop    (pop),
        .rd_data(head_bits),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign head            = entry_t'(head_bits);
    assign bus.in_ready    = !full;
    assign bus.out_valid   = !empty;
    assign bus.out_imm     = head.imm;
    assign bus.out_target  = head.target;
    assign bus.out_illegal = head.illegal;
    assign bus.out_count   = count;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: XLEN=32/DEPTH=2 and XLEN=64/DEPTH=3.
// Expected values are hand-derived from the immediate format definitions.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.XLEN(32), .DEPTH(2)) b32 ();
    imm_ext_pipe_if #(.XLEN(64), .DEPTH(3)) b64 ();

    imm_ext_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .bus(b32.slave)
    );
    imm_ext_pipe #(.XLEN(64), .DEPTH(3)) dut64 (
        .clk(clk), .rst(rst), .bus(b64.slave)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        b32.flush = 0; b32.in_valid = 0; b32.in_instr = 0;
        b32.in_imm_src = 0; b32.in_pc = 0; b32.out_ready = 0;
        b64.flush = 0; b64.in_valid = 0; b64.in_instr = 0;
        b64.in_imm_src = 0; b64.in_pc = 0; b64.out_ready = 0;
    endtask

    task automatic send32(input logic [31:0] instr, input logic [2:0] src,
                          input logic [31:0] pc);
        b32.in_instr = instr; b32.in_imm_src = src; b32.in_pc = pc;
        b32.in_valid = 1;
        @(negedge clk);
        b32.in_valid = 0;
    endtask

    task automatic pop32();
        b32.out_ready = 1;
        @(negedge clk);
        b32.out_ready = 0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [2:0] src,
                          input logic [63:0] pc);
        b64.in_instr = instr; b64.in_imm_src = src; b64.in_pc = pc;
        b64.in_valid = 1;
        @(negedge clk);
        b64.in_valid = 0;
    endtask

    task automatic pop64();
        b64.out_ready = 1;
        @(negedge clk);
        b64.out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        checks++;
        if (b32.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid: got %b expected 0", b32.out_valid);
        end
        checks++;
        if (b32.out_count !== 2'd0) begin
            errors++; $display("FAIL reset out_count: got %0d expected 0", b32.out_count);
        end
        checks++;
        if (b32.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %b expected 1", b32.in_ready);
        end
        checks++;
        if ({b32.out_imm, b32.out_target, b32.out_illegal} !== 65'd0) begin
            errors++; $display("FAIL reset head fields: got %h %h %b expected 0",
                               b32.out_imm, b32.out_target, b32.out_illegal);
        end
        checks++;
        if (b64.out_count !== 2'd0 || b64.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset64 count/ready: got %0d/%b expected 0/1",
                               b64.out_count, b64.in_ready);
        end
    endtask

    task automatic test_formats32();
        vec_t v[$];
        v.push_back('{32'hFFF00093, 3'd0, 64'h100, 64'hFFFFFFFF, 64'hFF, 1'b0});
        v.push_back('{32'h7FF00013, 3'd0, 64'h0, 64'h7FF, 64'h7FF, 1'b0});
        v.push_back('{32'hFE000FE3, 3'd1, 64'h200, 64'hFFFFFFFE, 64'h1FE, 1'b0});
        v.push_back('{32'hFE000EE3, 3'd1, 64'h200, 64'hFFFFFFFC, 64'h1FC, 1'b0});
        v.push_back('{32'hFE000EE3, 3'd1, 64'h0, 64'hFFFFFFFC, 64'hFFFFFFFC, 1'b0});
        v.push_back('{32'hFE000E23, 3'd2, 64'h40, 64'hFFFFFFFC, 64'h3C, 1'b0});
        v.push_back('{32'h00A00423, 3'd2, 64'h10, 64'h8, 64'h18, 1'b0});
        v.push_back('{32'h00100000, 3'd3, 64'h1000, 64'h800, 64'h1800, 1'b0});
        v.push_back('{32'h000FF000, 3'd3, 64'h0, 64'hFF000, 64'hFF000, 1'b0});
        v.push_back('{32'h80000000, 3'd3, 64'h100000, 64'hFFF00000, 64'h0, 1'b0});
        v.push_back('{32'h800002B7, 3'd4, 64'h10, 64'h80000000, 64'h80000010, 1'b0});
        v.push_back('{32'h01F00013, 3'd5, 64'h0, 64'h1F, 64'h1F, 1'b0});
        v.push_back('{32'h03F00013, 3'd5, 64'h300, 64'h0, 64'h300, 1'b1});
`ifdef IMM_EXT_ZICSR_EN
        v.push_back('{32'h300AD073, 3'd6, 64'h20, 64'h15, 64'h35, 1'b0});
`else
        v.push_back('{32'h300AD073, 3'd6, 64'h20, 64'h0, 64'h20, 1'b1});
`endif
        v.push_back('{32'hFFF00093, 3'd7, 64'h400, 64'h0, 64'h400, 1'b1});
        foreach (v[n]) begin
            send32(v[n].instr, v[n].src, v[n].pc[31:0]);
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_imm !== v[n].imm[31:0] ||
                b32.out_target !== v[n].tgt[31:0] ||
                b32.out_illegal !== v[n].ill) begin
                errors++;
                $display("FAIL fmt32[%0d]: got v=%b imm=%h tgt=%h ill=%b expected v=1 imm=%h tgt=%h ill=%b",
                         n, b32.out_valid, b32.out_imm, b32.out_target,
                         b32.out_illegal, v[n].imm[31:0], v[n].tgt[31:0], v[n].ill);
            end
            pop32();
        end
    endtask

    task automatic test_formats64();
        vec_t v[$];
        v.push_back('{32'h800002B7, 3'd4, 64'h0, 64'hFFFFFFFF80000000,
                      64'hFFFFFFFF80000000, 1'b0});
        v.push_back('{32'h7FFFF037, 3'd4, 64'h1, 64'h7FFFF000, 64'h7FFFF001, 1'b0});
        v.push_back('{32'h03F00013, 3'd5, 64'h1000, 64'h3F, 64'h103F, 1'b0});
        v.push_back('{32'hFFF00093, 3'd0, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'hFF, 1'b0});
        v.push_back('{32'hFE000EE3, 3'd1, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                      64'hFFFFFFFFFFFFFFFC, 1'b0});
        v.push_back('{32'h80000000, 3'd3, 64'h8000000000000000,
                      64'hFFFFFFFFFFF00000, 64'h7FFFFFFFFFF00000, 1'b0});
`ifdef IMM_EXT_ZICSR_EN
        v.push_back('{32'h300AD073, 3'd6, 64'h20, 64'h15, 64'h35, 1'b0});
`else
        v.push_back('{32'h300AD073, 3'd6, 64'h20, 64'h0, 64'h20, 1'b1});
`endif
        v.push_back('{32'hFFF00093, 3'd7, 64'h1234, 64'h0, 64'h1234, 1'b1});
        foreach (v[n]) begin
            send64(v[n].instr, v[n].src, v[n].pc);
            checks++;
            if (b64.out_valid !== 1'b1 || b64.out_imm !== v[n].imm ||
                b64.out_target !== v[n].tgt || b64.out_illegal !== v[n].ill) begin
                errors++;
                $display("FAIL fmt64[%0d]: got v=%b imm=%h tgt=%h ill=%b expected v=1 imm=%h tgt=%h ill=%b",
                         n, b64.out_valid, b64.out_imm, b64.out_target,
                         b64.out_illegal, v[n].imm, v[n].tgt, v[n].ill);
            end
            pop64();
        end
    endtask

    task automatic test_back_to_back();
        b32.out_ready = 0;
        b32.in_imm_src = 3'd0; b32.in_pc = 32'h0;
        b32.in_valid = 1;
        b32.in_instr = 32'h00100013;
        @(negedge clk);
        b32.in_instr = 32'h00200013;
        @(negedge clk);
        checks++;
        if (b32.in_ready !== 1'b0 || b32.out_count !== 2'd2) begin
            errors++; $display("FAIL b2b full: got ready=%b count=%0d expected 0/2",
                               b32.in_ready, b32.out_count);
        end
        b32.in_instr = 32'h00300013;
        @(negedge clk);
        checks++;
        if (b32.out_count !== 2'd2 || b32.out_imm !== 32'h1) begin
            errors++; $display("FAIL b2b held: got count=%0d imm=%h expected 2/1",
                               b32.out_count, b32.out_imm);
        end
        b32.out_ready = 1;
        @(negedge clk);
        checks++;
        if (b32.out_count !== 2'd1 || b32.out_imm !== 32'h2) begin
            errors++; $display("FAIL b2b full pop: got count=%0d imm=%h expected 1/2",
                               b32.out_count, b32.out_imm);
        end
        @(negedge clk);
        checks++;
        if (b32.out_count !== 2'd1 || b32.out_imm !== 32'h3) begin
            errors++; $display("FAIL b2b push+pop: got count=%0d imm=%h expected 1/3",
                               b32.out_count, b32.out_imm);
        end
        b32.in_valid = 0;
        @(negedge clk);
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_count !== 2'd0) begin
            errors++; $display("FAIL b2b drained: got valid=%b count=%0d expected 0/0",
                               b32.out_valid, b32.out_count);
        end
        b32.out_ready = 0;
    endtask

    task automatic test_flush();
        send32(32'h00500013, 3'd0, 32'h0);
        send32(32'h00600013, 3'd0, 32'h0);
        b32.in_instr = 32'h00700013; b32.in_valid = 1; b32.flush = 1;
        @(negedge clk);
        b32.flush = 0; b32.in_valid = 0;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_count !== 2'd0 ||
            b32.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush full: got valid=%b count=%0d ready=%b expected 0/0/1",
                               b32.out_valid, b32.out_count, b32.in_ready);
        end
        send32(32'h00800013, 3'd0, 32'h0);
        b32.in_instr = 32'h00900013; b32.in_valid = 1;
        b32.out_ready = 1; b32.flush = 1;
        @(negedge clk);
        b32.flush = 0; b32.in_valid = 0; b32.out_ready = 0;
        checks++;
        if (b32.out_count !== 2'd0 || b32.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush push+pop: got count=%0d valid=%b expected 0/0",
                               b32.out_count, b32.out_valid);
        end
        send32(32'h00A00013, 3'd0, 32'h0);
        checks++;
        if (b32.out_count !== 2'd1 || b32.out_imm !== 32'hA) begin
            errors++; $display("FAIL flush dropped beat: got count=%0d imm=%h expected 1/a",
                               b32.out_count, b32.out_imm);
        end
        pop32();
    endtask

    task automatic test_reset_mid();
        send32(32'hFFF00093, 3'd0, 32'h100);
        send32(32'h80000000, 3'd3, 32'h55);
        b32.in_instr = 32'h00700013; b32.in_valid = 1;
        b32.flush = 1; rst = 1;
        @(negedge clk);
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_count !== 2'd0 ||
            b32.in_ready !== 1'b1 || b32.out_imm !== 32'h0 ||
            b32.out_target !== 32'h0 || b32.out_illegal !== 1'b0) begin
            errors++; $display("FAIL reset mid: got v=%b c=%0d r=%b imm=%h tgt=%h ill=%b expected all 0, ready 1",
                               b32.out_valid, b32.out_count, b32.in_ready,
                               b32.out_imm, b32.out_target, b32.out_illegal);
        end
        rst = 0; b32.flush = 0; b32.in_valid = 0;
        @(negedge clk);
        checks++;
        if (b32.out_count !== 2'd0 || b32.out_target !== 32'h0) begin
            errors++; $display("FAIL reset release: got count=%0d tgt=%h expected 0/0",
                               b32.out_count, b32.out_target);
        end
    endtask

    initial begin
        test_reset();
        test_formats32();
        test_formats64();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
